// File: rtl/cm0_pmu_sync_filt.sv
// Multi-channel synchroniser for PMU wake/status inputs from foreign clock domains:
// per-channel flop chain, optional consecutive-sample glitch filter, rise/fall pulses.
module cm0_pmu_sync_filt #(
    parameter int                 WIDTH    = 4,
    parameter int                 STAGES   = 2,
    parameter logic [WIDTH-1:0]   RSTVAL   = {WIDTH{1'b1}},
    parameter int                 FILT_CYC = 3
) (
    input  logic             SYNCCLK,
    input  logic             SYNCRESETn,
    input  logic [WIDTH-1:0] SYNCDI,
    output logic [WIDTH-1:0] SYNCDO,
    output logic [WIDTH-1:0] SYNCRISE,
    output logic [WIDTH-1:0] SYNCFALL
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cm0_pmu_sync_filt: WIDTH must be in 1..32");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("cm0_pmu_sync_filt: STAGES must be in 2..4");
    end
    if (FILT_CYC < 0 || FILT_CYC > 15) begin : g_bad_filt
        $error("cm0_pmu_sync_filt: FILT_CYC must be in 0..15");
    end

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_lvl;
    logic [WIDTH-1:0] r_prev;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch

        // These flops are the ones mapped onto library synchroniser cells.
        logic [STAGES-1:0] r_sync;

        always_ff @(posedge SYNCCLK or negedge SYNCRESETn) begin
            if (!SYNCRESETn) begin
                r_sync <= {STAGES{RSTVAL[gi]}};
            end else begin
                r_sync <= {r_sync[STAGES-2:0], SYNCDI[gi]};
            end
        end

        assign w_s[gi] = r_sync[STAGES-1];

        if (FILT_CYC == 0) begin : g_bypass
            assign w_lvl[gi] = w_s[gi];
        end else begin : g_filter
            localparam logic [3:0] LP_CNT_LAST = 4'(FILT_CYC - 1);

            logic       r_lvl;
            logic [3:0] r_cnt;

            // Any sample matching the held level discards the pending count.
            always_ff @(posedge SYNCCLK or negedge SYNCRESETn) begin
                if (!SYNCRESETn) begin
                    r_lvl <= RSTVAL[gi];
                    r_cnt <= 4'd0;
                end else if (w_s[gi] == r_lvl) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    r_lvl <= w_s[gi];
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            assign w_lvl[gi] = r_lvl;
        end
    end

    // History resets to RSTVAL so neither reset entry nor exit produces a pulse.
    always_ff @(posedge SYNCCLK or negedge SYNCRESETn) begin
        if (!SYNCRESETn) begin
            r_prev <= RSTVAL;
        end else begin
            r_prev <= w_lvl;
        end
    end

    assign SYNCDO   = w_lvl;
    assign SYNCRISE = w_lvl & ~r_prev;
    assign SYNCFALL = ~w_lvl & r_prev;

`ifdef ARM_ASSERT_ON
    a_di_known: assert property (@(posedge SYNCCLK) disable iff (!SYNCRESETn)
        !$isunknown(SYNCDI))
        else $fatal(1, "cm0_pmu_sync_filt: X on SYNCDI out of reset");

    a_no_overlap: assert property (@(posedge SYNCCLK) disable iff (!SYNCRESETn)
        (SYNCRISE & SYNCFALL) == '0)
        else $fatal(1, "cm0_pmu_sync_filt: SYNCRISE and SYNCFALL high together");
`endif

endmodule

// File: tb/tb_cm0_pmu_sync_filt.sv
// Bench for cm0_pmu_sync_filt: default filtered instance plus a bypass instance
// (STAGES=3, FILT_CYC=0), checked against directed expectations and a sample-history model.
module tb_cm0_pmu_sync_filt;

    localparam int SA   = 2;
    localparam int FA   = 3;
    localparam int SB   = 3;
    localparam int MAXE = 20000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] di_a, di_b;
    logic [3:0] do_a, rise_a, fall_a;
    logic [3:0] do_b, rise_b, fall_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cm0_pmu_sync_filt dut (
        .SYNCCLK(clk), .SYNCRESETn(rst_n), .SYNCDI(di_a),
        .SYNCDO(do_a), .SYNCRISE(rise_a), .SYNCFALL(fall_a)
    );

    cm0_pmu_sync_filt #(.WIDTH(4), .STAGES(SB), .RSTVAL(4'hF), .FILT_CYC(0)) dut_byp (
        .SYNCCLK(clk), .SYNCRESETn(rst_n), .SYNCDI(di_b),
        .SYNCDO(do_b), .SYNCRISE(rise_b), .SYNCFALL(fall_b)
    );

    // Reference model: every input sample is logged by edge number; the synced
    // value after edge n is the sample taken at edge n-S+1 (reset value if that
    // precedes the last reset release). The filtered level flips when the last
    // FA synced values seen by the filter all disagree with it.
    logic [3:0] samp_a [0:MAXE];
    logic [3:0] samp_b [0:MAXE];
    int         n_edge     = 0;
    int         first_edge = 1;
    logic [3:0] m_do_a = 4'hF, m_prev_a = 4'hF;
    logic [3:0] m_do_b = 4'hF, m_prev_b = 4'hF;

    function automatic logic [3:0] s_at(input bit sel_b, input int stg, input int idx);
        int j;
        j = idx - stg + 1;
        if (j < first_edge || j < 0 || j > MAXE) return 4'hF;
        return sel_b ? samp_b[j] : samp_a[j];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_edge = n_edge + 1;
            m_do_a = 4'hF; m_prev_a = 4'hF;
            m_do_b = 4'hF; m_prev_b = 4'hF;
        end else begin
            logic [3:0] nd, sv;
            bit         all_diff;
            n_edge = n_edge + 1;
            if (n_edge <= MAXE) begin
                samp_a[n_edge] = di_a;
                samp_b[n_edge] = di_b;
            end
            m_prev_a = m_do_a;
            nd = m_do_a;
            for (int c = 0; c < 4; c++) begin
                all_diff = 1'b1;
                for (int k = 0; k < FA; k++) begin
                    sv = s_at(1'b0, SA, n_edge - 1 - k);
                    if (sv[c] == m_do_a[c]) all_diff = 1'b0;
                end
                if (all_diff) nd[c] = ~m_do_a[c];
            end
            m_do_a   = nd;
            m_prev_b = m_do_b;
            m_do_b   = s_at(1'b1, SB, n_edge);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; di_a = 4'h0; di_b = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (do_a !== 4'hF || rise_a !== 4'h0 || fall_a !== 4'h0) begin
                n_err++;
                $display("FAIL reset_hold do=%h rise=%h fall=%h expected F/0/0", do_a, rise_a, fall_a);
            end
            n_cmp++;
            if (do_b !== 4'hF || rise_b !== 4'h0 || fall_b !== 4'h0) begin
                n_err++;
                $display("FAIL reset_hold_byp do=%h rise=%h fall=%h expected F/0/0", do_b, rise_b, fall_b);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (do_a !== 4'hF || rise_a !== 4'h0 || fall_a !== 4'h0) begin
            n_err++;
            $display("FAIL reset_release do=%h rise=%h fall=%h expected F/0/0", do_a, rise_a, fall_a);
        end
        di_a = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({do_a, rise_a, fall_a} !== {m_do_a, m_do_a & ~m_prev_a, ~m_do_a & m_prev_a}) begin
                n_err++;
                $display("FAIL reset_settle do/rise/fall=%h/%h/%h expected %h/%h/%h", do_a, rise_a, fall_a,
                         m_do_a, m_do_a & ~m_prev_a, ~m_do_a & m_prev_a);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] e_do, e_fall;
        @(negedge clk);
        di_a = 4'hE;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e_do   = (k >= 5) ? 4'hE : 4'hF;
            e_fall = (k == 5) ? 4'h1 : 4'h0;
            n_cmp++;
            if (do_a !== e_do || fall_a !== e_fall || rise_a !== 4'h0) begin
                n_err++;
                $display("FAIL latency edge%0d do=%h fall=%h rise=%h expected %h/%h/0", k, do_a, fall_a, rise_a, e_do, e_fall);
            end
        end
        di_a = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e_do = (k >= 5) ? 4'hF : 4'hE;
            n_cmp++;
            if (do_a !== e_do || rise_a !== ((k == 5) ? 4'h1 : 4'h0) || fall_a !== 4'h0) begin
                n_err++;
                $display("FAIL latency_back edge%0d do=%h rise=%h fall=%h expected do %h", k, do_a, rise_a, fall_a, e_do);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] e_do, e_fall, e_rise;
        @(negedge clk);
        di_a = 4'hD;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (do_a !== 4'hF || rise_a !== 4'h0 || fall_a !== 4'h0) begin
                n_err++;
                $display("FAIL glitch2 edge%0d do=%h rise=%h fall=%h expected F/0/0", k, do_a, rise_a, fall_a);
            end
            if (k == 2) di_a = 4'hF;
        end
        di_a = 4'hD;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            e_do   = (k >= 5 && k < 8) ? 4'hD : 4'hF;
            e_fall = (k == 5) ? 4'h2 : 4'h0;
            e_rise = (k == 8) ? 4'h2 : 4'h0;
            n_cmp++;
            if (do_a !== e_do || rise_a !== e_rise || fall_a !== e_fall) begin
                n_err++;
                $display("FAIL glitch3 edge%0d do=%h rise=%h fall=%h expected %h/%h/%h", k, do_a, rise_a, fall_a,
                         e_do, e_rise, e_fall);
            end
            if (k == 3) di_a = 4'hF;
        end
    endtask

    task automatic test_bypass();
        logic [3:0] e_do;
        @(negedge clk);
        di_b = 4'h5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e_do = (k >= 3) ? 4'h5 : 4'hF;
            n_cmp++;
            if (do_b !== e_do || fall_b !== ((k == 3) ? 4'hA : 4'h0) || rise_b !== 4'h0) begin
                n_err++;
                $display("FAIL bypass edge%0d do=%h fall=%h rise=%h expected do %h", k, do_b, fall_b, rise_b, e_do);
            end
        end
        di_b = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({do_b, rise_b, fall_b} !== {m_do_b, m_do_b & ~m_prev_b, ~m_do_b & m_prev_b}) begin
                n_err++;
                $display("FAIL bypass_back edge%0d do/rise/fall=%h/%h/%h expected %h/%h/%h", k, do_b, rise_b, fall_b,
                         m_do_b, m_do_b & ~m_prev_b, ~m_do_b & m_prev_b);
            end
        end
    endtask

    task automatic test_reset_midcount();
        logic [3:0] e_do;
        @(negedge clk);
        di_a = 4'hB;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (do_a !== 4'hF || fall_a !== 4'h0 || rise_a !== 4'h0 || do_b !== 4'hF) begin
            n_err++;
            $display("FAIL midreset_async do=%h fall=%h rise=%h do_byp=%h expected F/0/0/F", do_a, fall_a, rise_a, do_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e_do = (k >= 5) ? 4'hB : 4'hF;
            n_cmp++;
            if (do_a !== e_do || fall_a !== ((k == 5) ? 4'h4 : 4'h0) || rise_a !== 4'h0) begin
                n_err++;
                $display("FAIL midreset_recount edge%0d do=%h fall=%h rise=%h expected do %h", k, do_a, fall_a, rise_a, e_do);
            end
        end
        di_a = 4'hF;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int ha[4], hb[4];
        for (int c = 0; c < 4; c++) begin ha[c] = 1; hb[c] = 1; end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if ({do_a, rise_a, fall_a} !== {m_do_a, m_do_a & ~m_prev_a, ~m_do_a & m_prev_a}) begin
                n_err++;
                $display("FAIL random_filt cyc%0d do/rise/fall=%h/%h/%h expected %h/%h/%h", cyc, do_a, rise_a, fall_a,
                         m_do_a, m_do_a & ~m_prev_a, ~m_do_a & m_prev_a);
            end
            n_cmp++;
            if ({do_b, rise_b, fall_b} !== {m_do_b, m_do_b & ~m_prev_b, ~m_do_b & m_prev_b}) begin
                n_err++;
                $display("FAIL random_byp cyc%0d do/rise/fall=%h/%h/%h expected %h/%h/%h", cyc, do_b, rise_b, fall_b,
                         m_do_b, m_do_b & ~m_prev_b, ~m_do_b & m_prev_b);
            end
            n_cmp++;
            if ((rise_a & fall_a) !== 4'h0 || (rise_b & fall_b) !== 4'h0) begin
                n_err++;
                $display("FAIL random_overlap cyc%0d rise&fall=%h byp=%h expected 0", cyc, rise_a & fall_a, rise_b & fall_b);
            end
            for (int c = 0; c < 4; c++) begin
                ha[c]--;
                if (ha[c] == 0) begin
                    di_a[c] = 1'($urandom_range(0, 1));
                    ha[c]   = $urandom_range(1, 6);
                end
                hb[c]--;
                if (hb[c] == 0) begin
                    di_b[c] = 1'($urandom_range(0, 1));
                    hb[c]   = $urandom_range(1, 4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_bypass();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
